// File: rtl/sdr_sram_responder.sv
`timescale 1ns/1ps
// SDRAM-port responder: services 2-beat multiplexer requests against a 16-bit async SRAM.
// Define SDR_RESP_HALF_SWAP_EN to service the high half first (big-endian word order).
module sdr_sram_responder #(
    parameter int SRAM_AW  = 18,
    parameter int WAIT_CYC = 2,
    parameter int WE_CYC   = 2
) (
    input  logic               iCLK,
    input  logic               iRST_n,
    input  logic [21:0]        iSDR_ADDR,
    input  logic [15:0]        iSDR_DATA,
    input  logic [1:0]         iSDR_DM,
    input  logic               iSDR_RD,
    input  logic               iSDR_WR,
    output logic [15:0]        oSDR_DATA,
    output logic               oSDR_RxD,
    output logic               oSDR_TxD,
    output logic               oSDR_Done,
    output logic [SRAM_AW-1:0] oSRAM_ADDR,
    output logic [15:0]        oSRAM_DQ,
    output logic               oSRAM_DQ_OE,
    input  logic [15:0]        iSRAM_DQ,
    output logic               oSRAM_CE_n,
    output logic               oSRAM_OE_n,
    output logic               oSRAM_WE_n,
    output logic               oSRAM_LB_n,
    output logic               oSRAM_UB_n
);

    // state  | meaning
    // IDLE   | waiting for RD/WR      W_SET1/2 | write address set-up, DM lag cover
    // W_STB  | WE_n strobe window     W_HOLD   | data hold after strobe
    // R_ADDR | read address phase     R_WAIT   | SRAM access time
    // R_CAP  | read data valid        DONE     | hold Done until request drops
    typedef enum logic [3:0] {
        IDLE, W_SET1, W_SET2, W_STB, W_HOLD, R_ADDR, R_WAIT, R_CAP, DONE
    } state_t;

`ifdef SDR_RESP_HALF_SWAP_EN
    localparam logic FIRST_HALF = 1'b1;
`else
    localparam logic FIRST_HALF = 1'b0;
`endif
    localparam logic [3:0] WE_LD   = 4'(WE_CYC - 1);
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC - 1);

    if (WAIT_CYC < 1 || WAIT_CYC > 15 || WE_CYC < 1 || WE_CYC > 15) begin : g_param_err
        $error("sdr_sram_responder: WAIT_CYC and WE_CYC must be in 1..15");
    end

    state_t             state, state_nx;
    logic [3:0]         cnt;
    logic               beat;
    logic [1:0]         dm_q;
    logic [15:0]        dq_q;
    logic [15:0]        rd_q;
    logic               txd_q;
    logic [SRAM_AW-1:0] sram_addr_q;
    logic               addr_unused;

    assign addr_unused = ^iSDR_ADDR[21:SRAM_AW-1];

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state       <= IDLE;
            cnt         <= '0;
            beat        <= 1'b0;
            dm_q        <= 2'b11;
            dq_q        <= '0;
            rd_q        <= '0;
            txd_q       <= 1'b0;
            sram_addr_q <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (iSDR_WR || iSDR_RD) begin
                        sram_addr_q <= {iSDR_ADDR[SRAM_AW-2:0], FIRST_HALF};
                        txd_q       <= FIRST_HALF;
                        beat        <= 1'b0;
                    end
                end
                W_SET2: begin
                    dq_q <= iSDR_DATA;
                    dm_q <= iSDR_DM;
                    cnt  <= WE_LD;
                end
                W_STB: begin
                    if (cnt != 4'd0) cnt <= cnt - 4'd1;
                end
                R_ADDR: cnt <= WAIT_LD;
                R_WAIT: begin
                    if (cnt == 4'd0) rd_q <= iSRAM_DQ;
                    else             cnt  <= cnt - 4'd1;
                end
                W_HOLD, R_CAP: begin
                    if (!beat) begin
                        beat           <= 1'b1;
                        sram_addr_q[0] <= ~FIRST_HALF;
                        txd_q          <= ~FIRST_HALF;
                    end
                end
                DONE: begin
                    if (!iSDR_RD && !iSDR_WR) begin
                        txd_q <= 1'b0;
                        beat  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (iSDR_WR)      state_nx = W_SET1;
                else if (iSDR_RD) state_nx = R_ADDR;
            end
            W_SET1: state_nx = W_SET2;
            W_SET2: state_nx = W_STB;
            W_STB:  if (cnt == 4'd0) state_nx = W_HOLD;
            W_HOLD: state_nx = beat ? DONE : W_SET1;
            R_ADDR: state_nx = R_WAIT;
            R_WAIT: if (cnt == 4'd0) state_nx = R_CAP;
            R_CAP:  state_nx = beat ? DONE : R_ADDR;
            DONE:   if (!iSDR_RD && !iSDR_WR) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        oSRAM_CE_n  = 1'b1;
        oSRAM_OE_n  = 1'b1;
        oSRAM_WE_n  = 1'b1;
        oSRAM_LB_n  = 1'b1;
        oSRAM_UB_n  = 1'b1;
        oSRAM_DQ_OE = 1'b0;
        case (state)
            W_SET1, W_SET2: oSRAM_CE_n = 1'b0;
            W_STB, W_HOLD: begin
                oSRAM_CE_n  = 1'b0;
                oSRAM_DQ_OE = 1'b1;
                oSRAM_LB_n  = dm_q[0];
                oSRAM_UB_n  = dm_q[1];
                // Fully masked beat keeps its timing slot but never strobes.
                oSRAM_WE_n  = !((state == W_STB) && (dm_q != 2'b11));
            end
            R_ADDR, R_WAIT, R_CAP: begin
                oSRAM_CE_n = 1'b0;
                oSRAM_OE_n = 1'b0;
                oSRAM_LB_n = 1'b0;
                oSRAM_UB_n = 1'b0;
            end
            default: ;
        endcase
    end

    assign oSDR_DATA  = rd_q;
    assign oSDR_RxD   = (state == R_CAP);
    assign oSDR_TxD   = txd_q;
    assign oSDR_Done  = (state == DONE);
    assign oSRAM_ADDR = sram_addr_q;
    assign oSRAM_DQ   = dq_q;

endmodule

// File: doc/sdr_sram_responder.md
Name: sdr_sram_responder

Overview:
- Target-side responder on the SDRAM port of the memory multiplexer. It accepts the multiplexed RD/WR/ADDR/DATA/DM request and services it against a 16-bit asynchronous SRAM.
- Each request is a 2-beat transfer (low half, then high half). The block generates TxD (half select), RxD (read-data strobe) and Done back toward the multiplexer.
- Lets the multiplexer and its async clients run unchanged on SRAM-based boards.

Parameters:
- SRAM_AW, 18, SRAM address width. SRAM address = {iSDR_ADDR[SRAM_AW-2:0], beat}.
- WAIT_CYC, 2, read access wait cycles per beat. Legal range 1..15.
- WE_CYC, 2, cycles WE_n is held low per write beat. Legal range 1..15.

Ports:
- iCLK  in  1  clock; all state changes on the rising edge.
- iRST_n  in  1  reset, asynchronous, active-low.
- iSDR_ADDR  in  22  request word address.
- iSDR_DATA  in  16  write data for the current half.
- iSDR_DM  in  2  byte mask for the current half; 1 = byte masked.
- iSDR_RD  in  1  read request level.
- iSDR_WR  in  1  write request level.
- oSDR_DATA  out  16  read data, registered.
- oSDR_RxD  out  1  read data valid strobe.
- oSDR_TxD  out  1  half select: 0 = low half, 1 = high half.
- oSDR_Done  out  1  transfer complete.
- oSRAM_ADDR  out  SRAM_AW  SRAM address.
- oSRAM_DQ  out  16  SRAM write data.
- oSRAM_DQ_OE  out  1  drive enable for the top-level tristate.
- iSRAM_DQ  in  16  SRAM read data.
- oSRAM_CE_n, oSRAM_OE_n, oSRAM_WE_n, oSRAM_LB_n, oSRAM_UB_n  out  1 each  SRAM strobes, active-low.

Behaviour:
- Reset, asynchronous and effective immediately, including mid-transfer:
  - all SRAM strobes = 1, oSRAM_DQ_OE = 0, oSRAM_ADDR = 0, oSRAM_DQ = 0;
  - oSDR_DATA = 0, oSDR_RxD/TxD/Done = 0;
  - FSM to IDLE, beat counter = 0.
- IDLE: samples iSDR_WR/iSDR_RD each edge.
  - WR has priority if both are high.
  - On the accepting edge, latch the address and operation. Later request changes are ignored until DONE.
- Write beat b (b = 0, 1):
  - W_SET1, W_SET2: 2 cycles. oSDR_TxD = b; ADDR driven; CE_n = 0.
  - End of W_SET2: register iSDR_DATA → oSRAM_DQ and iSDR_DM → {UB_n, LB_n}. The two set-up cycles cover the multiplexer's 1-cycle DM register lag.
  - W_STB: WE_CYC cycles. DQ_OE = 1; WE_n = 0 unless DM == 2'b11. A fully masked beat is skipped with no strobe but keeps the same cycle count.
  - W_HOLD: 1 cycle. WE_n = 1; DQ_OE stays 1.
  - After that: b = 0 → next beat; b = 1 → DONE.
- Read beat b:
  - R_ADDR: 1 cycle. oSDR_TxD = b; CE_n = 0, OE_n = 0, LB_n = UB_n = 0.
  - R_WAIT: WAIT_CYC cycles.
  - End of the last R_WAIT: iSRAM_DQ → oSDR_DATA.
  - R_CAP: 1 cycle. oSDR_RxD = 1, exactly one cycle per beat. oSDR_DATA holds until the next capture.
- DONE:
  - oSDR_Done = 1; all SRAM strobes high; DQ_OE = 0; TxD held at its last value.
  - Done stays high while iSDR_RD or iSDR_WR is high.
  - First edge with both low → IDLE, Done = 0, TxD = 0.
  - A request dropped mid-transfer does not abort it: the transfer completes, Done is high for 1 cycle, then IDLE.
- Latency, default parameters, k = accepting edge:
  - Write: 5 cycles per beat; Done high in cycle k+11.
  - Read: 4 cycles per beat; RxD high in cycles k+4 and k+8; Done high in cycle k+9.
- No back-to-back overlap: a new request can be accepted no earlier than the cycle after Done falls.
- Counters are 4-bit. WAIT_CYC/WE_CYC outside 1..15 is unsupported; a simulation-only check flags it.

Optional Feature:
- Macro SDR_RESP_HALF_SWAP_EN.
- Defined: beat 0 services the high half (TxD = 1, SRAM address LSB = 1) and beat 1 the low half, for big-endian word order. Latencies are unchanged.
- Undefined: low half first, as described above.

Test Plan:
- Write ADDR = 0x000010, DATA low = 0x1234 then high = 0xABCD, DM = 00 → WE_n pulses 2 cycles at SRAM addr 0x20 = 0x1234 and at 0x21 = 0xABCD; LB_n = UB_n = 0; Done in cycle k+11.
- Read ADDR = 0x000010 with the SRAM model holding 0x1234/0xABCD → RxD in k+4 with oSDR_DATA = 0x1234, RxD in k+8 with 0xABCD; Done in k+9; Done held until RD falls.
- Write with DM = 2'b10 on beat 0 and 2'b11 on beat 1 → beat 0: UB_n = 1, LB_n = 0, WE_n pulses; beat 1: no WE_n pulse; Done still in k+11.
- RD and WR both high in IDLE → write sequence runs, no OE_n assertion; Done in k+11.
- iRST_n low during W_STB of beat 1 → WE_n, CE_n = 1 and DQ_OE = 0 immediately; Done = 0; after release a read request completes normally.
- Compiled with SDR_RESP_HALF_SWAP_EN, read of 0x000010 → first RxD carries SRAM addr 0x21 with TxD = 1, second carries 0x20 with TxD = 0.
